// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and default geometry for the VGA plot arbiter
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CLEAR = 2'd2
    } arb_state_t;

    localparam int DEF_X_W     = 8;
    localparam int DEF_Y_W     = 7;
    localparam int DEF_COLOR_W = 3;
    localparam int DEF_X_MAX   = 159;
    localparam int DEF_Y_MAX   = 119;

    typedef struct packed {
        logic [DEF_X_W-1:0]     x;
        logic [DEF_Y_W-1:0]     y;
        logic [DEF_COLOR_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/vga_clear_sweep.sv
// rtl/vga_clear_sweep.sv - raster x/y sweep that emits one fill pixel per cycle
module vga_clear_sweep
    import vga_pkg::*;
#(
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [DEF_COLOR_W-1:0] color,
    output logic                   busy,
    output logic                   done,
    output pixel_t                 pixel
);

    localparam logic [DEF_X_W-1:0] X_LAST = DEF_X_W'(X_MAX);
    localparam logic [DEF_Y_W-1:0] Y_LAST = DEF_Y_W'(Y_MAX);

    logic [DEF_X_W-1:0]     x_cnt;
    logic [DEF_Y_W-1:0]     y_cnt;
    logic [DEF_COLOR_W-1:0] colour_q;

    // Colour is captured once at start so the caller may change it mid-sweep.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy     <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            colour_q <= '0;
        end else if (start && !busy) begin
            busy     <= 1'b1;
            x_cnt    <= '0;
            y_cnt    <= '0;
            colour_q <= color;
        end else if (busy) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                if (y_cnt == Y_LAST) begin
                    y_cnt <= '0;
                    busy  <= 1'b0;
                end else begin
                    y_cnt <= y_cnt + 1'b1;
                end
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    assign done         = busy && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign pixel.x      = x_cnt;
    assign pixel.y      = y_cnt;
    assign pixel.colour = colour_q;

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - burst-locked round-robin share of the vga_adapter write port
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int X_MAX   = DEF_X_MAX,
    parameter int Y_MAX   = DEF_Y_MAX
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    input  logic                       clear_req,
    input  logic [COLOR_W-1:0]         clear_color,
    output logic                       clear_busy,
    output logic [1:0]                 grant_id,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COLOR_W-1:0]         vga_colour,
    output logic                       vga_plot,
    output logic                       oor_drop
);

    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    arb_state_t         state;
    logic [1:0]         pointer;
    logic               clear_pending;

    logic [3:0]         valid_pad;
    logic [3:0]         last_pad;
    logic [3:0]         ready_pad;
    logic               xfer;
    logic               own_last;
    logic [X_W-1:0]     own_x;
    logic [Y_W-1:0]     own_y;
    logic [COLOR_W-1:0] own_color;
    logic               own_oor;

    logic               pick_found;
    logic [1:0]         pick_idx;
    logic [2:0]         pick_sum;
    logic [1:0]         next_ptr;
    logic               clear_accept;

    logic               sweep_start;
    logic               sweep_busy;
    logic               sweep_done;
    pixel_t             sweep_pixel;

    // Pad per-requester vectors to four bits so a 2-bit index is always legal.
    always_comb begin
        valid_pad                = '0;
        last_pad                 = '0;
        valid_pad[NUM_REQ-1:0]   = req_valid;
        last_pad[NUM_REQ-1:0]    = req_last;
    end

    // Only the owner sees ready, and only while the grant is held.
    assign ready_pad = (state == GRANT) ? (4'b0001 << grant_id) : 4'b0000;
    assign req_ready = ready_pad[NUM_REQ-1:0];
    assign xfer      = |(valid_pad & ready_pad);
    assign own_last  = last_pad[grant_id];

    // Select the owner's beat fields out of the packed request buses.
    always_comb begin
        own_x     = '0;
        own_y     = '0;
        own_color = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                own_x     = req_x[i*X_W +: X_W];
                own_y     = req_y[i*Y_W +: Y_W];
                own_color = req_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign own_oor = (own_x > X_LIM) || (own_y > Y_LIM);

    // Round-robin search: first valid index at or above pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = pointer;
        pick_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pick_sum = {1'b0, pointer} + 3'(k);
            if (pick_sum >= 3'(NUM_REQ)) begin
                pick_sum = pick_sum - 3'(NUM_REQ);
            end
            if (!pick_found && valid_pad[pick_sum[1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = pick_sum[1:0];
            end
        end
    end

    assign next_ptr     = (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
    assign clear_accept = clear_req && !clear_pending && (state != CLEAR);
    assign sweep_start  = (state == IDLE) && clear_pending;

    vga_clear_sweep #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_sweep (
        .clk    (clk),
        .resetn (resetn),
        .start  (sweep_start),
        .color  (clear_color),
        .busy   (sweep_busy),
        .done   (sweep_done),
        .pixel  (sweep_pixel)
    );

    // Arbitration FSM: pending clear beats requesters, grants release only on a last beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            pointer       <= 2'd0;
            grant_id      <= 2'd0;
            clear_pending <= 1'b0;
        end else begin
            if (clear_accept) begin
                clear_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clear_pending) begin
                        state <= CLEAR;
                    end else if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer && own_last) begin
                        pointer <= next_ptr;
                        state   <= IDLE;
                    end
                end
                CLEAR: begin
                    if (sweep_done) begin
                        clear_pending <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: one cycle after acceptance, out-of-range beats become a drop pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            oor_drop   <= 1'b0;
            clear_busy <= 1'b0;
        end else begin
            clear_busy <= sweep_busy;
            if (xfer) begin
                vga_x      <= own_x;
                vga_y      <= own_y;
                vga_colour <= own_color;
                vga_plot   <= !own_oor;
                oor_drop   <= own_oor;
            end else if (sweep_busy) begin
                vga_x      <= sweep_pixel.x;
                vga_y      <= sweep_pixel.y;
                vga_colour <= sweep_pixel.colour;
                vga_plot   <= 1'b1;
                oor_drop   <= 1'b0;
            end else begin
                vga_plot   <= 1'b0;
                oor_drop   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - scoreboard bench for vga_plot_arbiter
module tb_vga_plot_arbiter;

    typedef struct {
        int x;
        int y;
        int c;
        bit oor;
        int cyc;
        bit is_clear;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_last;
    logic [15:0] req_x;
    logic [13:0] req_y;
    logic [5:0]  req_color;
    logic        clear_req;
    logic [2:0]  clear_color;
    logic        clear_busy;
    logic [1:0]  grant_id;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        oor_drop;

    logic        v  [2];
    logic        l  [2];
    logic [7:0]  bx [2];
    logic [6:0]  by [2];
    logic [2:0]  bc [2];

    assign req_valid = {v[1], v[0]};
    assign req_last  = {l[1], l[0]};
    assign req_x     = {bx[1], bx[0]};
    assign req_y     = {by[1], by[0]};
    assign req_color = {bc[1], bc[0]};

    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   clear_seen = 0;
    bit   in_burst = 0;
    int   burst_owner = 0;
    exp_t exp_q[$];
    int   grant_log[$];

    vga_plot_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_last    (req_last),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_color   (req_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .grant_id    (grant_id),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .oor_drop    (oor_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t mk(input int x, input int y, input int c, input bit oor,
                                input int ecyc, input bit is_clear);
        exp_t e;
        e.x = x; e.y = y; e.c = c; e.oor = oor; e.cyc = ecyc; e.is_clear = is_clear;
        return e;
    endfunction

    // Monitor: handshake ownership/burst-lock model plus scoreboard of the plot port.
    always @(negedge clk) begin
        if (!resetn) begin
            in_burst = 0;
        end else begin
            int   owner;
            exp_t e;
            owner = -1;
            for (int i = 0; i < 2; i++) begin
                if (v[i] && req_ready[i]) owner = i;
            end
            if (req_ready != 2'b00) check("ready_onehot", $countones(req_ready), 1);
            if (owner >= 0) begin
                if (in_burst) check("burst_lock", owner, burst_owner);
                else grant_log.push_back(owner);
                check("grant_id", grant_id, owner);
                in_burst    = !l[owner];
                burst_owner = owner;
            end
            if (vga_plot || oor_drop) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL unexpected_output: plot=%0b oor=%0b at (%0d,%0d), expected nothing",
                             vga_plot, oor_drop, vga_x, vga_y);
                end else begin
                    e = exp_q.pop_front();
                    check("vga_x", vga_x, e.x);
                    check("vga_y", vga_y, e.y);
                    check("vga_colour", vga_colour, e.c);
                    check("vga_plot", vga_plot, !e.oor);
                    check("oor_drop", oor_drop, e.oor);
                    check("clear_busy_tag", clear_busy, e.is_clear);
                    if (e.cyc >= 0) check("plot_latency", cyc, e.cyc);
                    if (e.is_clear) clear_seen++;
                end
            end
        end
    end

    task automatic send_beat(input int i, input int x, input int y, input int c,
                             input bit last, output int acc);
        int n;
        bit ok;
        v[i] = 1'b1; bx[i] = x[7:0]; by[i] = y[6:0]; bc[i] = c[2:0]; l[i] = last;
        n = 0; ok = 0; acc = -1;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1;
            else n++;
        end
        if (!ok) begin
            vectors++;
            fails++;
            $display("FAIL beat_timeout: req%0d at (%0d,%0d) never got ready", i, x, y);
        end else begin
            acc = cyc;
            exp_q.push_back(mk(x, y, c, (x > 159) || (y > 119), cyc + 1, 0));
        end
        @(posedge clk); #1;
        v[i] = 1'b0; l[i] = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        v[0] = 0; v[1] = 0; l[0] = 0; l[1] = 0;
        clear_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        grant_log.delete();
        clear_seen = 0;
        resetn = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vga_x"}, vga_x, 0);
        check({tag, "_vga_y"}, vga_y, 0);
        check({tag, "_vga_colour"}, vga_colour, 0);
        check({tag, "_vga_plot"}, vga_plot, 0);
        check({tag, "_clear_busy"}, clear_busy, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_oor_drop"}, oor_drop, 0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int acc;
        int n;
        resetn = 1'b0;
        v[0] = 0; v[1] = 0; l[0] = 0; l[1] = 0;
        bx[0] = 0; bx[1] = 0; by[0] = 0; by[1] = 0; bc[0] = 0; bc[1] = 0;
        clear_req = 1'b0;
        clear_color = 3'b000;
        #2;
        check_all_zero("reset");

        // Reset then idle
        do_reset();
        repeat (20) begin
            @(negedge clk);
            check("idle_plot", vga_plot, 0);
            check("idle_ready", req_ready, 0);
        end

        // Single burst from req0
        do_reset();
        @(posedge clk); #1;
        c0 = cyc;
        send_beat(0, 10, 5, 4, 0, acc); check("single_acc0", acc, c0 + 1);
        send_beat(0, 11, 5, 4, 0, acc); check("single_acc1", acc, c0 + 2);
        send_beat(0, 12, 5, 4, 1, acc); check("single_acc2", acc, c0 + 3);
        drain("single_drain", 20);
        @(negedge clk);
        check("single_after_plot", vga_plot, 0);
        check("single_after_ready", req_ready, 0);

        // Contention: two 2-beat bursts from each requester
        do_reset();
        @(posedge clk); #1;
        fork
            begin
                int a;
                send_beat(0, 20, 30, 1, 0, a);
                send_beat(0, 21, 30, 1, 1, a);
                send_beat(0, 22, 30, 1, 0, a);
                send_beat(0, 23, 30, 1, 1, a);
            end
            begin
                int a;
                send_beat(1, 40, 50, 2, 0, a);
                send_beat(1, 41, 50, 2, 1, a);
                send_beat(1, 42, 50, 2, 0, a);
                send_beat(1, 43, 50, 2, 1, a);
            end
        join
        drain("contend_drain", 20);
        check("contend_grants", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("contend_g0", grant_log[0], 0);
            check("contend_g1", grant_log[1], 1);
            check("contend_g2", grant_log[2], 0);
            check("contend_g3", grant_log[3], 1);
        end

        // Burst lock: req1 pauses mid-burst while req0 waits
        do_reset();
        @(posedge clk); #1;
        send_beat(1, 60, 70, 5, 0, acc);
        fork
            begin
                int a;
                send_beat(0, 1, 2, 6, 1, a);
            end
            begin
                int a;
                repeat (4) begin
                    @(negedge clk);
                    check("lock_ready0", req_ready[0], 0);
                end
                @(posedge clk); #1;
                send_beat(1, 61, 70, 5, 0, a);
                send_beat(1, 62, 70, 5, 1, a);
            end
        join
        drain("lock_drain", 20);
        check("lock_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("lock_g0", grant_log[0], 1);
            check("lock_g1", grant_log[1], 0);
        end

        // Clear requested during the second beat of a 4-beat burst
        do_reset();
        clear_color = 3'b011;
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) begin
            if (b == 1) clear_req = 1'b1;
            send_beat(0, 100 + b, 20, 7, b == 3, acc);
            clear_req = 1'b0;
        end
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                exp_q.push_back(mk(x, y, 3, 0, -1, 1));
            end
        end
        n = 0;
        while (!clear_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("clear_busy_rise", clear_busy, 1);
        clear_color = 3'b110;
        drain("clear_drain", 20000);
        check("clear_count", clear_seen, 19200);
        @(negedge clk);
        check("clear_busy_fall", clear_busy, 0);
        check("clear_plot_end", vga_plot, 0);
        send_beat(1, 5, 6, 2, 1, acc);
        drain("post_clear_drain", 20);

        // Out-of-range beats and an in-range corner
        do_reset();
        @(posedge clk); #1;
        send_beat(0, 160, 10, 3, 1, acc);
        send_beat(1, 10, 120, 3, 1, acc);
        send_beat(0, 159, 119, 4, 1, acc);
        drain("oor_drain", 20);
        @(negedge clk);
        check("oor_pulse_end", oor_drop, 0);

        // Reset in the middle of a clear sweep
        do_reset();
        clear_color = 3'b101;
        @(posedge clk); #1;
        clear_req = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            exp_q.push_back(mk(k % 160, k / 160, 5, 0, -1, 1));
        end
        @(posedge clk); #1;
        clear_req = 1'b0;
        n = 0;
        while (clear_seen < 4999 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk); #1;
        check("midclear_seen", clear_seen, 5000);
        resetn = 1'b0;
        #1;
        check_all_zero("midclear_reset");
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (40) begin
            @(negedge clk);
            check("midclear_no_resume", vga_plot, 0);
            check("midclear_busy_low", clear_busy, 0);
        end
        check("midclear_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, colour, plot) between NUM_REQ drawing engines, such as line drawers and a fill engine.
- Round-robin grants with burst locking, so a line or shape is never interleaved with another requester's pixels.
- Contains a built-in screen-clear sequencer that sweeps the 160x120 frame with a fixed colour on request.
- Sits between the drawing FSMs and vga_adapter in the top level.

Parameters:
- NUM_REQ, 2, number of pixel requesters (2..4).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOR_W, 3, colour width (one bit per channel).
- X_MAX, 159, last valid column.
- Y_MAX, 119, last valid row.

Ports:
- clk  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester pixel valid.
- req_ready  out  NUM_REQ  per-requester pixel accepted this cycle.
- req_last  in  NUM_REQ  marks the final pixel of a burst.
- req_x  in  NUM_REQ*X_W  packed x, requester i at bits [i*X_W +: X_W].
- req_y  in  NUM_REQ*Y_W  packed y.
- req_color  in  NUM_REQ*COLOR_W  packed colour.
- clear_req  in  1  single-cycle pulse requesting a full-screen clear.
- clear_color  in  COLOR_W  fill colour, sampled on the cycle the clear starts.
- clear_busy  out  1  high while the sweep runs.
- grant_id  out  2  index of the current owner; valid while state is GRANT.
- vga_x  out  X_W  to vga_adapter x.
- vga_y  out  Y_W  to vga_adapter y.
- vga_colour  out  COLOR_W  to vga_adapter colour.
- vga_plot  out  1  to vga_adapter plot.
- oor_drop  out  1  one-cycle pulse when an accepted pixel is out of range.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all outputs 0 (vga_*, clear_busy, grant_id, oor_drop).
  - Round-robin pointer=0; clear_pending=0.
- States are IDLE, GRANT and CLEAR.
- Handshake:
  - A beat transfers when req_valid[i] and req_ready[i] are both high.
  - req_ready is combinational: high only for the owner, only in GRANT, and at most one bit is set.
  - A requester holds x, y, colour and last stable while valid=1 and ready=0.
- Latency and throughput:
  - A beat accepted in cycle N drives vga_x, vga_y, vga_colour with vga_plot=1 in cycle N+1 (registered).
  - Throughput is one pixel per cycle.
  - vga_plot=0 in any cycle with no transfer.
- Range check:
  - A beat with x>X_MAX or y>Y_MAX is still accepted.
  - vga_plot stays 0 and oor_drop=1 in cycle N+1.
- Clear request:
  - clear_req sets clear_pending.
  - A clear_req while clear_pending=1 or in CLEAR is ignored.
- IDLE:
  - If clear_pending, go to CLEAR (clear has priority over requesters).
  - Else, if any req_valid, pick the first valid index searching upward from pointer (wrapping), set grant_id, and go to GRANT.
  - Arbitration costs one cycle: no ready in IDLE.
- GRANT:
  - The owner keeps the grant until a beat with req_last=1 transfers.
  - The owner dropping valid mid-burst does not release the grant (burst lock).
  - When the last beat transfers, pointer=grant_id+1 (mod NUM_REQ) and the block returns to IDLE.
  - A clear_req arriving mid-burst waits for the burst boundary.
- CLEAR:
  - Latch clear_color and set clear_busy=1.
  - Counters sweep x inner (0..X_MAX) and y outer (0..Y_MAX), with vga_plot=1 every cycle.
  - The sweep is exactly (X_MAX+1)*(Y_MAX+1) plot cycles (19200 by default).
  - After the (X_MAX, Y_MAX) pixel: clear_busy=0, clear_pending=0, go to IDLE.
  - No req_ready is issued in CLEAR.
- Simultaneous events:
  - A clear_req in the same cycle as the last beat is honoured next, from IDLE.
  - Several valids in IDLE resolve by round-robin order.
- Reset mid-burst or mid-clear aborts immediately to the reset values; no partial state survives.
- Widths: x and y counters are X_W and Y_W bits; X_MAX and Y_MAX must fit.

Decomposition:
- Package vga_pkg holds:
  - arb_state_t enum {IDLE, GRANT, CLEAR};
  - default X_MAX, Y_MAX, X_W, Y_W, COLOR_W;
  - a pixel_t struct {x, y, colour}.
- One sub-module, vga_clear_sweep, holds the x/y counter pair with start/busy/done and emits pixel_t.
- Arbitration, the pointer and the output register stay in the top of the block.

Test Plan:
- Reset then idle: all outputs 0.
  - Release reset, no requests -> vga_plot=0 and req_ready=0 for 20 cycles.
- Single burst:
  - Req0 sends 3 beats (10,5),(11,5),(12,5), colour 3'b100, last on the third.
  - Required: ready on cycles 2..4; vga_plot=1 on cycles 3..5 with matching coordinates; back to IDLE.
- Contention and fairness:
  - Both requesters hold valid, each sending 2-beat bursts.
  - Required: grant order 0,1,0,1; no interleaving inside a burst; grant_id matches the ready owner.
- Burst lock:
  - Req1 drops valid for 4 cycles mid-burst while req0 is valid.
  - Required: req0 never gets ready until req1's last beat transfers.
- Clear during a burst:
  - Assert clear_req at the second of 4 beats of req0's burst.
  - Required: burst completes; CLEAR starts; exactly 19200 plot cycles ending at (159,119) with the latched colour; clear_busy then falls.
- Out-of-range pixel and reset mid-clear:
  - Accept a beat at (160,10) -> oor_drop pulse, vga_plot=0.
  - Assert resetn=0 at sweep pixel 5000 -> all outputs 0 immediately; no resumption after release.
